// File: rtl/replica_pkg.sv
// Shared types and constants for the replica exchange sequencer.
package replica_pkg;

    localparam int SEQ_EXP_TERMS = 8;
    localparam int SEQ_SHIFT_LEN = 32;
    localparam int SEQ_RECIP_W   = 17;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_FIN,
        S_OPT,
        S_CHK,
        S_SHIFT,
        S_DONE
    } seq_state_t;

    // floor((2^w - 1) / k); k = 0 is an unused table slot
    function automatic logic [31:0] recip_f(input int w, input int k);
        logic [31:0] num;
        if (k <= 0) return '0;
        num = (32'd1 << w) - 32'd1;
        return num / 32'(k);
    endfunction

endpackage

// File: rtl/replica_recip_rom.sv
// Reciprocal term table for the exp series, indexed by term number k.
module replica_recip_rom
    import replica_pkg::*;
#(
    parameter int RECIP_W = SEQ_RECIP_W
) (
    input  logic [3:0]         k_i,
    output logic [RECIP_W-1:0] recip_o
);

    logic [RECIP_W-1:0] tbl [16];

    for (genvar i = 0; i < 16; i++) begin : g_tbl
        assign tbl[i] = RECIP_W'(recip_f(RECIP_W, i));
    end

    assign recip_o = tbl[k_i];

endmodule

// File: rtl/replica_exchange_seq.sv
// Per-round sequencer driving all replicas: exp init/run/fin, opt, shift window.
// Define REPLICA_SEQ_PERF_EN to add round_cnt / shift_cnt performance counters.
module replica_exchange_seq
    import replica_pkg::*;
#(
    parameter int EXP_TERMS = SEQ_EXP_TERMS,
    parameter int SHIFT_LEN = SEQ_SHIFT_LEN,
    parameter int RECIP_W   = SEQ_RECIP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               thr,
    input  logic               exchange_mtr_any,
    output logic               busy,
    output logic               done,
    output logic               exp_init,
    output logic               exp_run,
    output logic [RECIP_W-1:0] exp_recip,
    output logic               exp_fin,
    output logic               opt_run,
    output logic               exchange_shift_d
`ifdef REPLICA_SEQ_PERF_EN
    ,
    output logic [31:0]        round_cnt,
    output logic [31:0]        shift_cnt
`endif
);

    localparam logic [3:0] K_LAST   = 4'(EXP_TERMS);
    localparam logic [7:0] CNT_INIT = 8'(SHIFT_LEN - 1);

    seq_state_t         state_q;
    logic [3:0]         k_q;
    logic [7:0]         cnt_q;
    logic               thr_q;
    logic               busy_q;
    logic               done_q;
    logic               init_q;
    logic               run_q;
    logic               fin_q;
    logic               opt_q;
    logic               shift_q;
    logic [RECIP_W-1:0] recip_q;
    logic [3:0]         rom_k;
    logic [RECIP_W-1:0] recip_d;

    // Table is looked up one term ahead so exp_recip can be registered
    assign rom_k = k_q + 4'd1;

    replica_recip_rom #(
        .RECIP_W(RECIP_W)
    ) u_rom (
        .k_i    (rom_k),
        .recip_o(recip_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            thr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
            run_q   <= 1'b0;
            fin_q   <= 1'b0;
            opt_q   <= 1'b0;
            shift_q <= 1'b0;
            recip_q <= '0;
        end else begin
            done_q <= 1'b0;
            init_q <= 1'b0;
            fin_q  <= 1'b0;
            opt_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    k_q   <= '0;
                    cnt_q <= '0;
                    if (start) begin
                        busy_q <= 1'b1;
                        thr_q  <= thr;
                        if (thr) begin
                            state_q <= S_OPT;
                            opt_q   <= 1'b1;
                        end else begin
                            state_q <= S_INIT;
                            init_q  <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    state_q <= S_RUN;
                    run_q   <= 1'b1;
                    recip_q <= recip_d;
                    k_q     <= 4'd1;
                end
                S_RUN: begin
                    if (k_q == K_LAST) begin
                        state_q <= S_FIN;
                        run_q   <= 1'b0;
                        recip_q <= '0;
                        k_q     <= '0;
                        fin_q   <= 1'b1;
                    end else begin
                        k_q     <= rom_k;
                        recip_q <= recip_d;
                    end
                end
                S_FIN: begin
                    state_q <= S_OPT;
                    opt_q   <= 1'b1;
                end
                S_OPT: state_q <= S_CHK;
                S_CHK: begin
                    if (exchange_mtr_any && !thr_q) begin
                        state_q <= S_SHIFT;
                        shift_q <= 1'b1;
                        cnt_q   <= CNT_INIT;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= S_DONE;
                        shift_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef REPLICA_SEQ_PERF_EN
    logic [31:0] round_q;
    logic [31:0] shcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            round_q <= '0;
            shcnt_q <= '0;
        end else begin
            if (state_q == S_DONE) round_q <= round_q + 32'd1;
            if (state_q == S_CHK && exchange_mtr_any && !thr_q)
                shcnt_q <= shcnt_q + 32'd1;
        end
    end

    assign round_cnt = round_q;
    assign shift_cnt = shcnt_q;
`endif

    assign busy             = busy_q;
    assign done             = done_q;
    assign exp_init         = init_q;
    assign exp_run          = run_q;
    assign exp_recip        = recip_q;
    assign exp_fin          = fin_q;
    assign opt_run          = opt_q;
    assign exchange_shift_d = shift_q;

endmodule

// File: tb/tb_replica_exchange_seq.sv
// Randomized bench for replica_exchange_seq against a per-round schedule model.
module tb_replica_exchange_seq;

    localparam int ET = 8;
    localparam int SL = 32;
    localparam int W  = 17;

    logic         clk = 1'b0;
    logic         reset, start, thr, mtr;
    logic         busy, done, exp_init, exp_run, exp_fin, opt_run, shd;
    logic [W-1:0] exp_recip;
`ifdef REPLICA_SEQ_PERF_EN
    logic [31:0]  round_cnt, shift_cnt;
`endif

    replica_exchange_seq #(
        .EXP_TERMS(ET), .SHIFT_LEN(SL), .RECIP_W(W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .thr             (thr),
        .exchange_mtr_any(mtr),
        .busy            (busy),
        .done            (done),
        .exp_init        (exp_init),
        .exp_run         (exp_run),
        .exp_recip       (exp_recip),
        .exp_fin         (exp_fin),
        .opt_run         (opt_run),
        .exchange_shift_d(shd)
`ifdef REPLICA_SEQ_PERF_EN
        ,
        .round_cnt       (round_cnt),
        .shift_cnt       (shift_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One record per cycle of a round: what the outputs must show then
    typedef struct {
        bit          busy, done, init, run, fin, opt, shd;
        bit          chk, rthr;
        int unsigned recip;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    rec_t        idle_r;
    int unsigned m_rounds = 0;
    int unsigned m_shifts = 0;

    function automatic rec_t mk(input int kind, input int unsigned rc, input bit rt);
        rec_t r;
        r = '{default: 0};
        r.busy  = 1'b1;
        r.rthr  = rt;
        r.recip = rc;
        case (kind)
            0: r.init = 1'b1;
            1: r.run  = 1'b1;
            2: r.fin  = 1'b1;
            3: r.opt  = 1'b1;
            4: r.chk  = 1'b1;
            5: r.shd  = 1'b1;
            default: r.done = 1'b1;
        endcase
        return r;
    endfunction

    task automatic push_round(input bit t);
        if (!t) begin
            q.push_back(mk(0, 0, t));
            for (int k = 1; k <= ET; k++)
                q.push_back(mk(1, ((2 ** W) - 1) / k, t));
            q.push_back(mk(2, 0, t));
        end
        q.push_back(mk(3, 0, t));
        q.push_back(mk(4, 0, t));
    endtask

    initial idle_r = '{default: 0};

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur      = idle_r;
            m_rounds = 0;
            m_shifts = 0;
        end else begin
            if (cur.done) m_rounds++;
            if (cur.chk) begin
                if (mtr && !cur.rthr) begin
                    repeat (SL) q.push_back(mk(5, 0, cur.rthr));
                    m_shifts++;
                end
                q.push_back(mk(6, 0, cur.rthr));
            end
            if (!cur.busy && start) push_round(thr);
            cur = (q.size() > 0) ? q.pop_front() : idle_r;
        end
    end

    always @(negedge clk) begin
        chk("cycle_ctl", {busy, done, exp_init, exp_run, exp_fin, opt_run, shd},
            {cur.busy, cur.done, cur.init, cur.run, cur.fin, cur.opt, cur.shd});
        chk("cycle_recip", exp_recip, cur.recip);
`ifdef REPLICA_SEQ_PERF_EN
        chk("cycle_round_cnt", round_cnt, m_rounds);
        chk("cycle_shift_cnt", shift_cnt, m_shifts);
`endif
    end

    int unsigned lit[1:8] = '{131071, 65535, 43690, 32767, 26214, 21845, 18724, 16383};

    initial begin
        int n;
        bit got;
        int dn;
        bit sh;
        longint r0;
        start = 0; thr = 0; mtr = 0; reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_outs", {done, exp_init, exp_run, exp_fin, opt_run, shd}, 0);
        chk("idle_recip", exp_recip, 0);

        // plain exchange round
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t2_init", exp_init, 1);
        for (int k = 1; k <= ET; k++) begin
            @(negedge clk);
            chk("t2_run", exp_run, 1);
            chk("t2_recip", exp_recip, lit[k]);
        end
        @(negedge clk); chk("t2_fin", exp_fin, 1);
        @(negedge clk); chk("t2_opt", opt_run, 1);
        @(negedge clk); chk("t2_chk_nodone", done, 0);
        @(negedge clk); chk("t2_done", done, 1);
        @(negedge clk); chk("t2_busy_off", busy, 0);

        // round with a pending move -> shift window
        mtr = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        n = 0; got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (shd) n++;
            if (done) got = 1;
        end
        chk("t3_done_seen", got, 1);
        chk("t3_shift_len", n, SL);
`ifdef REPLICA_SEQ_PERF_EN
        chk("t3_shift_cnt", shift_cnt, 1);
`endif
        @(negedge clk);

        // THR round skips exp phase and never shifts
        thr = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t4_opt", opt_run, 1);
        chk("t4_noinit", exp_init, 0);
        sh = shd;
        @(negedge clk); sh |= shd;
        @(negedge clk); sh |= shd;
        chk("t4_done", done, 1);
        chk("t4_noshift", sh, 0);
        thr = 0; mtr = 0;
        @(negedge clk);

        // start held through a whole round
`ifdef REPLICA_SEQ_PERF_EN
        r0 = round_cnt;
`else
        r0 = 0;
`endif
        dn = 0;
        start = 1;
        repeat (14) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("t5_one_done", dn, 1);
`ifdef REPLICA_SEQ_PERF_EN
        chk("t5_round_inc", round_cnt - r0, 1);
`endif

        // reset in the middle of RUN
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("t6_run_k4", exp_recip, 32767);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("t6_rst_outs", {busy, done, exp_init, exp_run, exp_fin, opt_run, shd}, 0);
        chk("t6_rst_recip", exp_recip, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t6_init", exp_init, 1);
        repeat (12) @(negedge clk);
        chk("t6_done", done, 1);
        @(negedge clk);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            thr   = ($urandom_range(0, 3) == 0);
            mtr   = $urandom_range(0, 1) == 1;
            reset = ($urandom_range(0, 80) == 0);
        end
        @(negedge clk);
        start = 0; reset = 0;
        repeat (60) @(negedge clk);
        chk("end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
